// File: rtl/ram.sv
// 32x32 register-file RAM: synchronous write, combinational read, block enable,
// and an asynchronous active-low clear of every word.
module ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_en;

    assign wr_en = ena & wena;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[addr] = data_in;
        end
    end

    // Reset wins over any in-flight write, regardless of its timing against clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read port shows the stored word in both read and write modes; a deselected block drives 0.
    assign data_out = (rst_n && ena) ? mem_q[addr] : '0;

endmodule

// File: tb/tb_ram.sv
// Directed-vector bench for ram: reset clear, enable gating, write/read,
// overwrite, address isolation with combinational read, and reset during a write.
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int vectors;
    int miscompares;

    ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wena     (wena),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so inputs and samples sit away from it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        ena     = 1'b0;
        wena    = 1'b0;
        addr    = '0;
        data_in = '0;
        edge_step();
        edge_step();
        rst_n = 1'b1;
        edge_step();

        // Put a nonzero word at addr 1 so the reset clear is observable.
        ena = 1'b1; wena = 1'b1; addr = 5'd1; data_in = 32'hDEAD_BEEF;
        edge_step();
        wena = 1'b0;
        #1 chk("preload_a1", data_out, 32'hDEAD_BEEF);

        // Mid-cycle reset pulse with a read selected.
        #1 rst_n = 1'b0;
        #1 chk("rst_async_out", data_out, 32'h0);
        #1 rst_n = 1'b1;
        #1 chk("rst_cleared_a1", data_out, 32'h0);
        edge_step();
        for (int a = 0; a < 32; a++) begin
            addr = a[4:0];
            #1 chk($sformatf("rst_word_%0d", a), data_out, 32'h0);
        end

        // Disabled write must not land.
        ena = 1'b0; wena = 1'b1; addr = 5'd1; data_in = 32'hFFFF_FFFF;
        #1 chk("dis_out0", data_out, 32'h0);
        edge_step();
        chk("dis_out_e1", data_out, 32'h0);
        edge_step();
        chk("dis_out_e2", data_out, 32'h0);
        ena = 1'b1; wena = 1'b0;
        #1 chk("dis_no_write", data_out, 32'h0);

        // Basic write: old value before the edge, new value from the first edge on.
        wena = 1'b1; data_in = 32'hFFFF_FFFF;
        #1 chk("wr_pre_edge", data_out, 32'h0);
        edge_step();
        chk("wr_edge1", data_out, 32'hFFFF_FFFF);
        edge_step();
        chk("wr_edge2", data_out, 32'hFFFF_FFFF);
        wena = 1'b0; data_in = 32'h0;
        #1 chk("rd_hold", data_out, 32'hFFFF_FFFF);
        edge_step();
        chk("rd_hold_edge", data_out, 32'hFFFF_FFFF);
        ena = 1'b0;
        #1 chk("dis_read_zero", data_out, 32'h0);
        ena = 1'b1;
        #1 chk("reenable_held", data_out, 32'hFFFF_FFFF);

        // Overwrite with zero.
        wena = 1'b1; data_in = 32'h0;
        edge_step();
        chk("ovw_edge1", data_out, 32'h0);
        edge_step();
        wena = 1'b0;
        #1 chk("ovw_after", data_out, 32'h0);

        // Repeated writes to one address: last sampled data wins.
        wena = 1'b1; addr = 5'd7; data_in = 32'h1111_1111;
        edge_step();
        data_in = 32'h2222_2222;
        edge_step();
        wena = 1'b0;
        #1 chk("rewrite_last", data_out, 32'h2222_2222);

        // Isolation and combinational address tracking.
        wena = 1'b1; addr = 5'd0; data_in = 32'hA5A5_0001;
        edge_step();
        addr = 5'd31; data_in = 32'h5A5A_001F;
        edge_step();
        wena = 1'b0; data_in = 32'h0;
        addr = 5'd0;
        #1 chk("iso_a0", data_out, 32'hA5A5_0001);
        addr = 5'd1;
        #1 chk("iso_a1", data_out, 32'h0);
        addr = 5'd31;
        #1 chk("iso_a31", data_out, 32'h5A5A_001F);
        addr = 5'd7;
        #1 chk("iso_a7", data_out, 32'h2222_2222);
        addr = 5'd30;
        #1 chk("iso_a30", data_out, 32'h0);

        // Reset asserted together with a write: the write is aborted.
        ena = 1'b1; wena = 1'b1; addr = 5'd3; data_in = 32'h1234_5678; rst_n = 1'b0;
        #1 chk("rstw_out", data_out, 32'h0);
        edge_step();
        chk("rstw_in_reset", data_out, 32'h0);
        wena = 1'b0; data_in = 32'h0;
        #1 rst_n = 1'b1;
        #1 chk("rstw_a3", data_out, 32'h0);
        addr = 5'd0;
        #1 chk("rstw_a0", data_out, 32'h0);
        addr = 5'd31;
        #1 chk("rstw_a31", data_out, 32'h0);
        edge_step();

        // Normal operation resumes after release.
        wena = 1'b1; addr = 5'd3; data_in = 32'h1234_5678;
        edge_step();
        wena = 1'b0;
        #1 chk("post_rst_wr", data_out, 32'h1234_5678);
        addr = 5'd4;
        #1 chk("post_rst_neigh", data_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram.md
Name: ram

Overview:
- Single-port synchronous-write, asynchronous-read register-file RAM: 32 words x 32 bits.
- Used as a small scratch/data memory in simple datapaths.
- Block-level enable gates both access directions.
- Contents are cleared by the global asynchronous active-low reset.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 5, address bits.
- DEPTH, 2**ADDR_WIDTH (32), number of words; every address value is valid.

Ports:
- clk  input  1  system clock; all writes take effect on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all memory words.
- ena  input  1  block enable; high = RAM selected.
- wena  input  1  write enable; high with ena = write, low with ena = read.
- addr  input  ADDR_WIDTH  word address, 0..DEPTH-1.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data.

Behaviour:
- Reset:
  - While rst_n=0, all DEPTH words are forced to 0 immediately, without waiting for a clock edge.
  - Writes are ignored during reset.
  - data_out reads 0 during reset.
  - On release of rst_n, normal operation starts at the next rising clk edge.
- Write:
  - At rising clk with rst_n=1, ena=1 and wena=1, mem[addr] <= data_in.
  - One write per cycle. Write latency is 1 edge.
- Read:
  - Combinational. data_out = mem[addr] whenever ena=1 and wena=0.
  - Follows addr changes within the same cycle; no clock latency.
- Output while writing:
  - When ena=1 and wena=1, data_out = mem[addr].
  - Before the edge this is the old contents. After the edge it is the newly written value (write-first visible after the edge).
- Disabled:
  - When ena=0, data_out = 0. No tristate.
  - Memory contents are held.
  - wena is ignored, so no write occurs even if wena=1.
- Repeated writes:
  - Multiple edges with ena=wena=1 at the same addr rewrite each cycle.
  - The last data_in sampled wins.
- Other words:
  - A write to one address never disturbs other addresses.
- Reset mid-operation:
  - Asserting rst_n during an active write cycle aborts the write.
  - All words are 0 after reset regardless of timing relative to clk.
- No X propagation:
  - Every word has a defined value (0) after reset.
  - addr covers exactly DEPTH words, so there is no out-of-range case.

Test Plan:
- Reset: pulse rst_n low mid-cycle with ena=1, wena=0, addr=1 -> data_out=0 immediately; all addresses 0..31 read 0 afterwards.
- Disabled write: ena=0, wena=1, addr=1, data_in=FFFF_FFFF for 2 edges; then ena=1, wena=0 -> data_out=0000_0000. Also, data_out=0 whenever ena=0.
- Basic write/read:
  - ena=1, addr=1, data_in=FFFF_FFFF, wena=1 for 2 edges, then wena=0.
  - data_out=FFFF_FFFF from the first edge onward.
  - Hold data_in=0000_0000 with wena=0 -> data_out stays FFFF_FFFF.
- Overwrite: ena=1, addr=1, data_in=0000_0000, wena=1 for 2 edges -> data_out=0000_0000 after the first edge and stays 0 after wena drops.
- Isolation/async read:
  - Write A5A5_0001 to addr 0 and 5A5A_001F to addr 31.
  - Switch addr between 0, 1, 31 with wena=0, no clock edge -> data_out tracks 0xA5A5_0001, prior addr-1 value, 0x5A5A_001F combinationally.
- Reset during write: rst_n=0 coincident with ena=wena=1, data_in=1234_5678, addr=3 -> addr 3 reads 0 after reset release.
